// File: rtl/strobe_period_controller.sv
// Sequencer in front of counter_with_strobe: accepts period updates over valid/ready,
// applies them only at strobe boundaries, gates the counter enable and counts periods.
module strobe_period_controller #(
    parameter int WIDTH      = 32,
    parameter int MIN_PERIOD = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_period,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             cfg_applied,
    output logic             cnt_rst,
    output logic             cnt_enable,
    output logic [WIDTH-1:0] cnt_reset_value,
    input  logic             cnt_ready,
    input  logic             cnt_strobe,
    output logic [WIDTH-1:0] period_count
);

    localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_PENDING
    } state_t;

    state_t           state_q, state_d;
    logic             cfg_err_q, cfg_err_d;
    logic             swap_applied_q, swap_applied_d;
    logic [WIDTH-1:0] reset_value_q, reset_value_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             legal;

    assign legal = (cfg_period >= MIN_P);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cfg_err_q      <= 1'b0;
            swap_applied_q <= 1'b0;
            reset_value_q  <= MIN_P;
            pending_q      <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            cfg_err_q      <= cfg_err_d;
            swap_applied_q <= swap_applied_d;
            reset_value_q  <= reset_value_d;
            pending_q      <= pending_d;
            count_q        <= count_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cfg_err_d      = cfg_err_q;
        swap_applied_d = 1'b0;
        reset_value_d  = reset_value_q;
        pending_d      = pending_q;
        count_d        = count_q;
        cfg_ready      = 1'b0;
        cnt_rst        = 1'b0;
        cnt_enable     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    if (legal) begin
                        reset_value_d = cfg_period;
                        state_d       = ST_LOAD;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                cnt_rst = 1'b1;
                count_d = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cfg_ready  = 1'b1;
                cnt_enable = run & cnt_ready;
                if (cnt_strobe) begin
                    count_d = count_q + 1'b1;
                end
                if (cfg_valid) begin
                    if (legal) begin
                        pending_d = cfg_period;
                        state_d   = ST_PENDING;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_PENDING: begin
                // Enable is held low on the swap strobe so the counter sees the new value cleanly
                cnt_enable = run & cnt_ready & ~cnt_strobe;
                if (cnt_strobe) begin
                    reset_value_d  = pending_q;
                    swap_applied_d = 1'b1;
                    count_d        = '0;
                    state_d        = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cfg_err         = cfg_err_q;
    assign cfg_applied     = (state_q == ST_LOAD) | swap_applied_q;
    assign cnt_reset_value = reset_value_q;
    assign period_count    = count_q;

endmodule
